// File: rtl/lcd_hd44780_sink_if.sv
// HD44780 parallel bus as seen between the LCD write controller and the display end.
interface lcd_hd44780_sink_if;
  logic [7:0] LCD_DATA;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       LCD_RS;

  modport master (output LCD_DATA, LCD_RW, LCD_EN, LCD_RS);
  modport slave  (input  LCD_DATA, LCD_RW, LCD_EN, LCD_RS);
endinterface

// File: rtl/lcd_hd44780_sink.sv
// Display end of the HD44780 bus: decodes writes, keeps a 16x2 shadow of DDRAM,
// the address counter, busy timing and display flags.
//   state | meaning
//   IDLE  | ready, accepts the next bus write
//   CLEAR | blanking the shadow, one entry per cycle
//   BUSY  | counting down the remaining instruction time
module lcd_hd44780_sink #(
  parameter int CMD_CYCLES = 2000,
  parameter int CLR_CYCLES = 82000
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  lcd_hd44780_sink_if.slave   lcd,
  input  logic [4:0]          iRD_ADDR,
  output logic [7:0]          oRD_CHAR,
  output logic [6:0]          oAC,
  output logic                oBUSY,
  output logic                oDISP_ON,
  output logic                oLINES2,
  output logic                oWR_STB,
  output logic                oERR
);

  localparam int CW = $clog2(CLR_CYCLES + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;

  // bit 10 EN, bit 9 RW, bit 8 RS, bits 7:0 DATA
  logic [10:0]   sync1, sync2, sampPrev;
  logic          enFall;
  logic          evt, evtRs;
  logic [7:0]    evtData;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [4:0]    clrIdx;
  logic          entryInc;
  logic [7:0]    shadow [32];
  logic          wrValid;
  logic [4:0]    wrIdx;

  function automatic logic [6:0] stepAc(input logic [6:0] ac, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (ac == 7'h27)      nxt = 7'h40;
      else if (ac == 7'h67) nxt = 7'h00;
      else                  nxt = ac + 7'd1;
    end else begin
      if (ac == 7'h00)      nxt = 7'h67;
      else if (ac == 7'h40) nxt = 7'h27;
      else                  nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

  assign enFall  = sampPrev[10] & ~sync2[10];
  assign wrValid = (oAC[6:4] == 3'b000) || (oAC[6:4] == 3'b100);
  assign wrIdx   = {oAC[6], oAC[3:0]};
  assign oBUSY   = (state != IDLE);

  // RS/RW/DATA are taken from the last sample that still had EN high
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync1    <= '0;
      sync2    <= '0;
      sampPrev <= '0;
      evt      <= 1'b0;
      evtRs    <= 1'b0;
      evtData  <= '0;
    end else begin
      sync1    <= {lcd.LCD_EN, lcd.LCD_RW, lcd.LCD_RS, lcd.LCD_DATA};
      sync2    <= sync1;
      sampPrev <= sync2;
      evt      <= enFall & ~sampPrev[9];
      evtRs    <= sampPrev[8];
      evtData  <= sampPrev[7:0];
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < 32; i++) shadow[i] <= 8'h20;
      state    <= IDLE;
      cnt      <= '0;
      clrIdx   <= '0;
      entryInc <= 1'b1;
      oAC      <= '0;
      oDISP_ON <= 1'b0;
      oLINES2  <= 1'b0;
      oWR_STB  <= 1'b0;
      oERR     <= 1'b0;
      oRD_CHAR <= 8'h20;
    end else begin
      oWR_STB  <= 1'b0;
      oRD_CHAR <= shadow[iRD_ADDR];
      if (evt && state != IDLE) oERR <= 1'b1;
      case (state)
        IDLE: begin
          if (evt && evtRs) begin
            if (wrValid) shadow[wrIdx] <= evtData;
            oWR_STB <= 1'b1;
            oAC     <= stepAc(oAC, entryInc);
            state   <= BUSY;
            cnt     <= CW'(CMD_CYCLES - 1);
          end else if (evt && evtData != 8'h00) begin
            state <= BUSY;
            cnt   <= CW'(CMD_CYCLES - 1);
            casez (evtData)
              8'b1???????: oAC <= evtData[6:0];
              8'b01??????: ;
              8'b001?????: oLINES2 <= evtData[3];
              8'b0001????: ;
              8'b00001???: oDISP_ON <= evtData[2];
              8'b000001??: entryInc <= evtData[1];
              8'b0000001?: begin
                oAC <= '0;
                cnt <= CW'(CLR_CYCLES - 1);
              end
              default: begin
                oAC      <= '0;
                entryInc <= 1'b1;
                clrIdx   <= '0;
                state    <= CLEAR;
              end
            endcase
          end
        end
        CLEAR: begin
          shadow[clrIdx] <= 8'h20;
          clrIdx         <= clrIdx + 5'd1;
          if (clrIdx == 5'd31) begin
            state <= BUSY;
            cnt   <= CW'(CLR_CYCLES - 33);
          end
        end
        BUSY: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_sink.sv
module tb_lcd_hd44780_sink;
  localparam int CMD = 200;
  localparam int CLR = 400;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic [4:0] iRD_ADDR = '0;
  logic [7:0] oRD_CHAR;
  logic [6:0] oAC;
  logic       oBUSY, oDISP_ON, oLINES2, oWR_STB, oERR;

  lcd_hd44780_sink_if bus();

  lcd_hd44780_sink #(.CMD_CYCLES(CMD), .CLR_CYCLES(CLR)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .lcd(bus),
    .iRD_ADDR(iRD_ADDR), .oRD_CHAR(oRD_CHAR), .oAC(oAC), .oBUSY(oBUSY),
    .oDISP_ON(oDISP_ON), .oLINES2(oLINES2), .oWR_STB(oWR_STB), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  int errors = 0;
  int checks = 0;
  int busyCnt = 0;
  int stbCnt = 0;

  always @(negedge iCLK) begin
    if (oBUSY === 1'b1) busyCnt++;
    if (oWR_STB === 1'b1) stbCnt++;
  end

  // reference model of the panel
  logic [7:0] mBuf [32];
  int         mAc;
  bit         mId, mDisp, mLines, mErr;
  logic [7:0] dutBuf [32];

  function automatic int mIdx(input int a);
    if (a < 16) return a;
    if (a >= 64 && a < 80) return a - 48;
    return -1;
  endfunction

  function automatic int mStep(input int a, input bit inc);
    if (inc) begin
      if (a == 39) return 64;
      if (a == 103) return 0;
      return (a + 1) % 128;
    end
    if (a == 0) return 103;
    if (a == 64) return 39;
    return (a + 127) % 128;
  endfunction

  function automatic int mDur(input bit rs, input logic [7:0] d);
    if (rs) return CMD;
    if (d == 8'h00) return 0;
    if (d <= 8'h03) return CLR;
    return CMD;
  endfunction

  task automatic mReset();
    for (int i = 0; i < 32; i++) mBuf[i] = 8'h20;
    mAc = 0; mId = 1; mDisp = 0; mLines = 0; mErr = 0;
  endtask

  task automatic mApply(input bit rs, input logic [7:0] d);
    int k;
    if (rs) begin
      k = mIdx(mAc);
      if (k >= 0) mBuf[k] = d;
      mAc = mStep(mAc, mId);
    end
    else if (d >= 8'h80) mAc = int'(d) - 128;
    else if (d >= 8'h40) ;
    else if (d >= 8'h20) mLines = d[3];
    else if (d >= 8'h10) ;
    else if (d >= 8'h08) mDisp = d[2];
    else if (d >= 8'h04) mId = d[1];
    else if (d >= 8'h02) mAc = 0;
    else if (d == 8'h01) begin
      for (int i = 0; i < 32; i++) mBuf[i] = 8'h20;
      mAc = 0; mId = 1;
    end
  endtask

  task automatic lcdWrite(input bit rs, input bit rw, input logic [7:0] d);
    @(negedge iCLK);
    bus.LCD_RS = rs; bus.LCD_RW = rw; bus.LCD_DATA = d;
    repeat (2) @(negedge iCLK);
    bus.LCD_EN = 1'b1;
    repeat (4) @(negedge iCLK);
    bus.LCD_EN = 1'b0;
    repeat (4) @(negedge iCLK);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (oBUSY !== 1'b0 && n < 5000) begin
      @(negedge iCLK);
      n++;
    end
    if (n >= 5000) begin
      errors++; checks++;
      $display("FAIL wait_idle: oBUSY=%b still high after %0d cycles, required 0", oBUSY, n);
    end
  endtask

  task automatic doWrite(input bit rs, input logic [7:0] d);
    lcdWrite(rs, 1'b0, d);
    waitIdle();
    mApply(rs, d);
    @(negedge iCLK);
  endtask

  task automatic readAll();
    for (int i = 0; i < 32; i++) begin
      @(negedge iCLK);
      iRD_ADDR = 5'(i);
      @(negedge iCLK);
      dutBuf[i] = oRD_CHAR;
    end
  endtask

  task automatic test_reset();
    mReset();
    repeat (3) @(negedge iCLK);
    checks++; if (oAC !== 7'h00) begin errors++; $display("FAIL reset_ac: got %h, required 00", oAC); end
    checks++; if ({oBUSY, oWR_STB, oERR} !== 3'b000) begin errors++; $display("FAIL reset_flags: busy/stb/err got %b, required 000", {oBUSY, oWR_STB, oERR}); end
    checks++; if ({oDISP_ON, oLINES2} !== 2'b00) begin errors++; $display("FAIL reset_disp: disp/lines got %b, required 00", {oDISP_ON, oLINES2}); end
    checks++; if (oRD_CHAR !== 8'h20) begin errors++; $display("FAIL reset_rdchar: got %h, required 20", oRD_CHAR); end
    iRST_N = 1'b1;
    repeat (3) @(negedge iCLK);
  endtask

  task automatic test_init();
    logic [7:0] seq [5];
    seq[0] = 8'h38; seq[1] = 8'h0C; seq[2] = 8'h01; seq[3] = 8'h06; seq[4] = 8'h80;
    for (int i = 0; i < 5; i++) begin
      doWrite(1'b0, seq[i]);
      repeat (50) @(negedge iCLK);
    end
    checks++; if (oLINES2 !== 1'b1) begin errors++; $display("FAIL init_lines2: got %b, required 1", oLINES2); end
    checks++; if (oDISP_ON !== 1'b1) begin errors++; $display("FAIL init_disp: got %b, required 1", oDISP_ON); end
    checks++; if (oAC !== 7'(mAc)) begin errors++; $display("FAIL init_ac: got %h, required %h", oAC, 7'(mAc)); end
    checks++; if (oERR !== 1'b0) begin errors++; $display("FAIL init_err: got %b, required 0", oERR); end
    readAll();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dutBuf[i] !== 8'h20) begin errors++; $display("FAIL init_buf[%0d]: got %h, required 20", i, dutBuf[i]); end
    end
  endtask

  task automatic test_data();
    logic [7:0] ch [2];
    ch[0] = 8'h50; ch[1] = 8'h61;
    stbCnt = 0;
    for (int i = 0; i < 2; i++) begin
      busyCnt = 0;
      doWrite(1'b1, ch[i]);
      checks++; if (busyCnt != mDur(1'b1, ch[i])) begin errors++; $display("FAIL data_busy_len: got %0d cycles, required %0d", busyCnt, mDur(1'b1, ch[i])); end
    end
    checks++; if (stbCnt != 2) begin errors++; $display("FAIL data_stb_count: got %0d, required 2", stbCnt); end
    checks++; if (oAC !== 7'(mAc)) begin errors++; $display("FAIL data_ac: got %h, required %h", oAC, 7'(mAc)); end
    readAll();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dutBuf[i] !== mBuf[i]) begin errors++; $display("FAIL data_buf[%0d]: got %h, required %h", i, dutBuf[i], mBuf[i]); end
    end
  endtask

  task automatic test_line2();
    doWrite(1'b0, 8'hC0);
    doWrite(1'b1, 8'h44);
    checks++; if (oAC !== 7'(mAc)) begin errors++; $display("FAIL line2_ac: got %h, required %h", oAC, 7'(mAc)); end
    doWrite(1'b0, 8'hA7);
    doWrite(1'b1, 8'h41);
    checks++; if (oAC !== 7'(mAc)) begin errors++; $display("FAIL wrap27_ac: got %h, required %h", oAC, 7'(mAc)); end
    readAll();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dutBuf[i] !== mBuf[i]) begin errors++; $display("FAIL line2_buf[%0d]: got %h, required %h", i, dutBuf[i], mBuf[i]); end
    end
  endtask

  task automatic test_decrement();
    doWrite(1'b0, 8'h04);
    doWrite(1'b0, 8'h80);
    doWrite(1'b1, 8'h58);
    checks++; if (oAC !== 7'(mAc)) begin errors++; $display("FAIL dec_wrap00_ac: got %h, required %h", oAC, 7'(mAc)); end
    doWrite(1'b0, 8'hC0);
    doWrite(1'b1, 8'h59);
    checks++; if (oAC !== 7'(mAc)) begin errors++; $display("FAIL dec_wrap40_ac: got %h, required %h", oAC, 7'(mAc)); end
    readAll();
    checks++; if (dutBuf[0] !== mBuf[0]) begin errors++; $display("FAIL dec_buf0: got %h, required %h", dutBuf[0], mBuf[0]); end
    checks++; if (dutBuf[16] !== mBuf[16]) begin errors++; $display("FAIL dec_buf16: got %h, required %h", dutBuf[16], mBuf[16]); end
    doWrite(1'b0, 8'h06);
  endtask

  task automatic test_random();
    logic [7:0] edgeAddr [9];
    logic [7:0] d;
    bit rs;
    int r;
    edgeAddr[0] = 8'h00; edgeAddr[1] = 8'h0F; edgeAddr[2] = 8'h27; edgeAddr[3] = 8'h40;
    edgeAddr[4] = 8'h4F; edgeAddr[5] = 8'h67; edgeAddr[6] = 8'h10; edgeAddr[7] = 8'h2A;
    edgeAddr[8] = 8'h7F;
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      rs = 1'b0;
      if (r <= 5) begin rs = 1'b1; d = 8'($urandom_range(33, 126)); end
      else if (r == 6) d = 8'h80 | edgeAddr[$urandom_range(0, 8)];
      else if (r == 7) d = 8'h80 | 8'($urandom_range(0, 127));
      else if (r == 8) d = 8'h04 | 8'($urandom_range(0, 3));
      else d = 8'h08 | 8'($urandom_range(0, 7));
      busyCnt = 0;
      doWrite(rs, d);
      checks++; if (oAC !== 7'(mAc)) begin errors++; $display("FAIL rand_ac it%0d: got %h, required %h", it, oAC, 7'(mAc)); end
      checks++; if (busyCnt != mDur(rs, d)) begin errors++; $display("FAIL rand_busy it%0d: got %0d, required %0d", it, busyCnt, mDur(rs, d)); end
    end
    checks++; if (oDISP_ON !== mDisp) begin errors++; $display("FAIL rand_disp: got %b, required %b", oDISP_ON, mDisp); end
    readAll();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dutBuf[i] !== mBuf[i]) begin errors++; $display("FAIL rand_buf[%0d]: got %h, required %h", i, dutBuf[i], mBuf[i]); end
    end
    doWrite(1'b0, 8'h06);
  endtask

  task automatic test_busy_drop();
    doWrite(1'b0, 8'h80);
    stbCnt = 0;
    lcdWrite(1'b1, 1'b0, 8'h4D);
    mApply(1'b1, 8'h4D);
    repeat (88) @(negedge iCLK);
    lcdWrite(1'b1, 1'b0, 8'h4E);
    mErr = 1;
    waitIdle();
    repeat (300) @(negedge iCLK);
    checks++; if (oERR !== mErr) begin errors++; $display("FAIL drop_err: got %b, required %b", oERR, mErr); end
    checks++; if (oAC !== 7'(mAc)) begin errors++; $display("FAIL drop_ac: got %h, required %h", oAC, 7'(mAc)); end
    checks++; if (stbCnt != 1) begin errors++; $display("FAIL drop_stb: got %0d, required 1", stbCnt); end
    readAll();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dutBuf[i] !== mBuf[i]) begin errors++; $display("FAIL drop_buf[%0d]: got %h, required %h", i, dutBuf[i], mBuf[i]); end
    end
  endtask

  task automatic test_clear_busy();
    doWrite(1'b1, 8'h6B);
    busyCnt = 0;
    doWrite(1'b0, 8'h02);
    checks++; if (busyCnt != mDur(1'b0, 8'h02)) begin errors++; $display("FAIL home_busy: got %0d, required %0d", busyCnt, mDur(1'b0, 8'h02)); end
    checks++; if (oAC !== 7'(mAc)) begin errors++; $display("FAIL home_ac: got %h, required %h", oAC, 7'(mAc)); end
    busyCnt = 0;
    doWrite(1'b0, 8'h00);
    checks++; if (busyCnt != 0) begin errors++; $display("FAIL nop_busy: got %0d, required 0", busyCnt); end
    busyCnt = 0;
    doWrite(1'b0, 8'h01);
    checks++; if (busyCnt != mDur(1'b0, 8'h01)) begin errors++; $display("FAIL clear_busy: got %0d, required %0d", busyCnt, mDur(1'b0, 8'h01)); end
    readAll();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dutBuf[i] !== mBuf[i]) begin errors++; $display("FAIL clear_buf[%0d]: got %h, required %h", i, dutBuf[i], mBuf[i]); end
    end
  endtask

  task automatic test_rw_ignored();
    doWrite(1'b1, 8'h37);
    busyCnt = 0;
    stbCnt = 0;
    lcdWrite(1'b0, 1'b1, 8'h01);
    lcdWrite(1'b1, 1'b1, 8'h5A);
    lcdWrite(1'b0, 1'b1, 8'hC5);
    repeat (10) @(negedge iCLK);
    checks++; if (busyCnt != 0) begin errors++; $display("FAIL rw_busy: got %0d, required 0", busyCnt); end
    checks++; if (stbCnt != 0) begin errors++; $display("FAIL rw_stb: got %0d, required 0", stbCnt); end
    checks++; if (oAC !== 7'(mAc)) begin errors++; $display("FAIL rw_ac: got %h, required %h", oAC, 7'(mAc)); end
    checks++; if (oERR !== mErr) begin errors++; $display("FAIL rw_err: got %b, required %b", oERR, mErr); end
    readAll();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dutBuf[i] !== mBuf[i]) begin errors++; $display("FAIL rw_buf[%0d]: got %h, required %h", i, dutBuf[i], mBuf[i]); end
    end
  endtask

  task automatic test_reset_mid_clear();
    doWrite(1'b0, 8'h38);
    doWrite(1'b0, 8'h80);
    for (int i = 0; i < 4; i++) doWrite(1'b1, 8'($urandom_range(65, 90)));
    lcdWrite(1'b0, 1'b0, 8'h01);
    repeat (8) @(negedge iCLK);
    checks++; if (oBUSY !== 1'b1) begin errors++; $display("FAIL midclr_busy: got %b, required 1", oBUSY); end
    #2 iRST_N = 1'b0;
    #1;
    mReset();
    checks++; if ({oBUSY, oERR, oWR_STB, oDISP_ON, oLINES2} !== 5'b0) begin errors++; $display("FAIL midclr_flags: got %b, required 00000", {oBUSY, oERR, oWR_STB, oDISP_ON, oLINES2}); end
    checks++; if (oAC !== 7'h00) begin errors++; $display("FAIL midclr_ac: got %h, required 00", oAC); end
    @(negedge iCLK);
    iRST_N = 1'b1;
    repeat (4) @(negedge iCLK);
    checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL midclr_idle: got %b, required 0", oBUSY); end
    readAll();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dutBuf[i] !== 8'h20) begin errors++; $display("FAIL midclr_buf[%0d]: got %h, required 20", i, dutBuf[i]); end
    end
    doWrite(1'b1, 8'h33);
    checks++; if (oAC !== 7'(mAc)) begin errors++; $display("FAIL postrst_ac: got %h, required %h", oAC, 7'(mAc)); end
  endtask

  initial begin
    bus.LCD_EN = 1'b0; bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b0; bus.LCD_DATA = 8'h00;
    test_reset();
    test_init();
    test_data();
    test_line2();
    test_decrement();
    test_random();
    test_busy_drop();
    test_clear_busy();
    test_rw_ignored();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
